// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller: accumulates capped credit from three coin
// denominations, vends one of N_ITEMS products and streams change/refunds one coin per cycle.
module vending_machine_multi #(
    parameter int CW = 8,
    parameter int N_ITEMS = 4,
    parameter logic [N_ITEMS*CW-1:0] PRICES = {8'd65, 8'd50, 8'd35, 8'd15},
    parameter int COIN1 = 5,
    parameter int COIN2 = 10,
    parameter int COIN3 = 25,
    parameter int MAX_CREDIT = 100,
    localparam int SW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic          clk,
    input  logic          R,
    input  logic [1:0]    in,
    input  logic [SW-1:0] sel,
    input  logic          buy,
    input  logic          cancel,
    output logic          out,
    output logic [SW-1:0] item,
    output logic [1:0]    ch,
    output logic [CW-1:0] credit,
    output logic          coin_rej,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Encoding order is IDLE=0, COLLECT=1, VEND=2, CHANGE=3 as seen on dbg_state.
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit_n;
    logic          out_n;
    logic [SW-1:0] item_n;
    logic [1:0]    ch_n;
    logic          coin_rej_n;
    logic          busy_n;

    logic [CW-1:0] price;
    logic          sel_ok;
    logic [CW:0]   coin_sum;
    logic [1:0]    pay;
    logic [CW-1:0] pay_val;

    function automatic logic [CW-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return CW'(COIN1);
            2'b10:   return CW'(COIN2);
            2'b11:   return CW'(COIN3);
            default: return '0;
        endcase
    endfunction

    // Greedy change: largest coin not exceeding the remaining credit.
    function automatic logic [1:0] change_coin(input logic [CW-1:0] amount);
        if (amount >= CW'(COIN3)) return 2'b11;
        if (amount >= CW'(COIN2)) return 2'b10;
        if (amount >= CW'(COIN1)) return 2'b01;
        return 2'b00;
    endfunction

    assign dbg_state = state;

    always_comb begin
        price  = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel == SW'(i)) begin
                price  = PRICES[i*CW +: CW];
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        coin_sum   = {1'b0, credit} + {1'b0, coin_value(in)};
        pay        = change_coin(credit);
        pay_val    = coin_value(pay);
        state_n    = state;
        credit_n   = credit;
        out_n      = 1'b0;
        item_n     = item;
        ch_n       = 2'b00;
        coin_rej_n = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel && credit != '0) begin
                    state_n    = CHANGE;
                    ch_n       = pay;
                    credit_n   = credit - pay_val;
                    coin_rej_n = (in != 2'b00);
                end else if (buy && sel_ok && credit >= price) begin
                    state_n    = VEND;
                    credit_n   = credit - price;
                    out_n      = 1'b1;
                    item_n     = sel;
                    coin_rej_n = (in != 2'b00);
                end else if (in != 2'b00) begin
                    if (coin_sum <= (CW+1)'(MAX_CREDIT)) begin
                        credit_n = coin_sum[CW-1:0];
                        state_n  = COLLECT;
                    end else begin
                        coin_rej_n = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_rej_n = (in != 2'b00);
                if (credit != '0) begin
                    state_n  = CHANGE;
                    ch_n     = pay;
                    credit_n = credit - pay_val;
                end else begin
                    state_n = IDLE;
                end
            end
            CHANGE: begin
                // The last coin is shown for one cycle with credit already 0; leave after it.
                coin_rej_n = (in != 2'b00);
                if (credit != '0 && pay != 2'b00) begin
                    ch_n     = pay;
                    credit_n = credit - pay_val;
                end else begin
                    state_n  = IDLE;
                    credit_n = '0;
                end
            end
            default: begin
                state_n  = IDLE;
                credit_n = '0;
            end
        endcase
        busy_n = (state_n == VEND) || (state_n == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state    <= IDLE;
            credit   <= '0;
            out      <= 1'b0;
            item     <= '0;
            ch       <= 2'b00;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            out      <= out_n;
            item     <= item_n;
            ch       <= ch_n;
            coin_rej <= coin_rej_n;
            busy     <= busy_n;
        end
    end

endmodule
